rsa_seq_ctrl: RTL and testbench
===============================

Name: rsa_seq_ctrl

Overview:
- Top-level sequencer for the modular-exponentiation datapath.
- Gates UART byte intake. Starts mon_exp once serial_to_parallel reports operands loaded, waits for completion, latches the answer and hands it to parallel_to_serial. Blocks new input until transmission finishes.
- Also owns the single merged BRAM write port, granting it to serial_to_parallel or mon_exp by phase.
- A run watchdog flags a hung exponentiation.

Parameters:
- BITLEN, 16, operand/answer width.
- ABITS, 8, BRAM address width.
- DBITS, 16, BRAM data width.
- TMO_BITS, 12, watchdog width; RUN aborts after 2^TMO_BITS cycles without mx_stop.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of the ERR state and the sticky flags.
- ld_valid  in  1  one-cycle pulse from serial_to_parallel: operands loaded.
- ld_wr_addr/ld_wr_data/ld_wr_en  in  ABITS/DBITS/1  loader write request.
- mx_wr_addr/mx_wr_data/mx_wr_en  in  ABITS/DBITS/1  mon_exp write request.
- wr_addr/wr_data/wr_en  out  ABITS/DBITS/1  merged BRAM write port, registered.
- mx_start  out  1  one-cycle start pulse to mon_exp.
- mx_stop  in  1  mon_exp done, level or pulse.
- mx_ans  in  BITLEN  mon_exp result, valid while mx_stop=1.
- tx_start  out  1  one-cycle pulse to parallel_to_serial.
- tx_data  out  BITLEN  latched answer, held until the next latch.
- tx_done  in  1  pulse: last byte sent.
- rx_enable  out  1  qualifies UART received into serial_to_parallel.
- busy  out  1  high in any state other than IDLE.
- err  out  1  high in ERR.
- coll  out  1  sticky: a write request was dropped.
- ovr  out  1  sticky: ld_valid arrived outside IDLE.
- state  out  3  current state encoding, for LEDs.

Behaviour:
- Reset values (async):
  - State is IDLE.
  - rx_enable=1.
  - All other outputs are 0, including tx_data, wr_*, the flags and the watchdog counter.
  - Reset mid-operation aborts immediately. In-flight BRAM writes are not completed.
- States and encodings: IDLE=0, START=1, RUN=2, SEND=3, WAIT_TX=4, ERR=5.
- IDLE:
  - rx_enable=1.
  - When ld_valid is seen at cycle t: START at t+1, with rx_enable=0 registered from t+1.
- START:
  - mx_start=1 for exactly this cycle.
  - The watchdog clears.
  - Always moves to RUN next cycle; mx_stop is ignored here.
- RUN:
  - The watchdog increments each cycle.
  - If mx_stop is seen at cycle s: tx_data<=mx_ans, and SEND at s+1.
  - Else if the watchdog is all-ones: ERR next cycle.
  - If mx_stop and the watchdog expiry occur in the same cycle, mx_stop wins.
- SEND:
  - tx_start=1 for this cycle only.
  - Moves to WAIT_TX next cycle.
  - tx_done is ignored here.
- WAIT_TX:
  - When tx_done is seen: IDLE next cycle, with rx_enable=1 from that cycle.
  - There is no timeout in this state.
- ERR:
  - rx_enable=0.
  - Stays in ERR until clr, then returns to IDLE. tx_data is unchanged.
- clr:
  - Clears coll and ovr in any state.
  - Clears ERR only when in ERR.
  - clr has priority over a flag being set in the same cycle.
- Write arbitration:
  - The owner is the loader in IDLE and the datapath in START/RUN. No one owns the port in SEND/WAIT_TX/ERR.
  - The owner's request is registered onto wr_* with 1-cycle latency.
  - A non-owner with wr_en=1 is dropped and sets coll.
  - When both requesters assert in the same cycle, only the owner passes.
  - When there is no owner, wr_en=0 and wr_addr/wr_data hold their last values.
- ld_valid outside IDLE is ignored and sets ovr.
- The watchdog is a TMO_BITS-wide counter that is active only in RUN; it does not wrap.

Decomposition:
- Shared package rsa_pkg holds:
  - the state enum/localparams (IDLE..ERR);
  - default BITLEN/ABITS/DBITS.
- Natural sub-module: bram_wr_arb, a registered 2-input write-port mux with owner select and drop flag.
- The FSM and watchdog stay in rsa_seq_ctrl.

Test Plan:
- Nominal flow:
  - Stimulus: rst, then ld_valid at t=10; mx_stop with mx_ans=16'h1234 at t=20; tx_done at t=40.
  - Required: mx_start high only at t=11; tx_data=16'h1234 and tx_start high at t=21; state returns to IDLE at t=41 with rx_enable=1.
- Write arbitration:
  - Stimulus: in IDLE, ld_wr_en with addr 8'h03, data 16'hBEEF and mx_wr_en both high at t.
  - Required: wr_en=1, wr_addr=8'h03, wr_data=16'hBEEF at t+1; coll=1.
  - Then in RUN, mx writes addr 8'h05 and passes.
- Watchdog:
  - Stimulus: TMO_BITS=4, no mx_stop.
  - Required: ERR (state=5, err=1) exactly 16 RUN cycles after entry.
  - Then clr returns to IDLE; a subsequent run completes normally.
- Overrun:
  - Stimulus: ld_valid during RUN and during WAIT_TX.
  - Required: no state change, ovr=1, no extra mx_start.
- Simultaneous events:
  - Stimulus: mx_stop and watchdog expiry in the same cycle.
  - Required: SEND, not ERR.
- Reset mid-operation:
  - Stimulus: rst asserted in WAIT_TX.
  - Required: IDLE, tx_data=0, rx_enable=1 without waiting for a clock edge.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding and default widths for the RSA sequencer
package rsa_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        ERR     = 3'd5
    } state_t;
    localparam int BITLEN_DEF = 16;
    localparam int ABITS_DEF  = 8;
    localparam int DBITS_DEF  = 16;
    localparam int TMO_DEF    = 12;
endpackage

// File: rtl/rsa_seq_ctrl_bram_wr_arb.sv
// bram_wr_arb: registered two-requester BRAM write mux; non-owner requests are dropped and flagged
module bram_wr_arb #(
    parameter int ABITS = 8,
    parameter int DBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             own_ld,
    input  logic             own_mx,
    input  logic [ABITS-1:0] ld_wr_addr,
    input  logic [DBITS-1:0] ld_wr_data,
    input  logic             ld_wr_en,
    input  logic [ABITS-1:0] mx_wr_addr,
    input  logic [DBITS-1:0] mx_wr_data,
    input  logic             mx_wr_en,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             drop
);
    logic pass_ld, pass_mx;
    always_comb begin
        pass_ld = own_ld & ld_wr_en;
        pass_mx = own_mx & mx_wr_en;
        drop    = (ld_wr_en & ~own_ld) | (mx_wr_en & ~own_mx);
    end
    // address/data hold their last values whenever nothing passes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pass_ld | pass_mx;
            if (pass_ld) begin
                wr_addr <= ld_wr_addr;
                wr_data <= ld_wr_data;
            end else if (pass_mx) begin
                wr_addr <= mx_wr_addr;
                wr_data <= mx_wr_data;
            end
        end
    end
endmodule

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: sequences operand load, mon_exp run, answer transmit, BRAM write ownership and run watchdog
module rsa_seq_ctrl
    import rsa_pkg::*;
#(
    parameter int BITLEN   = BITLEN_DEF,
    parameter int ABITS    = ABITS_DEF,
    parameter int DBITS    = DBITS_DEF,
    parameter int TMO_BITS = TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld_valid,
    input  logic [ABITS-1:0]  ld_wr_addr,
    input  logic [DBITS-1:0]  ld_wr_data,
    input  logic              ld_wr_en,
    input  logic [ABITS-1:0]  mx_wr_addr,
    input  logic [DBITS-1:0]  mx_wr_data,
    input  logic              mx_wr_en,
    output logic [ABITS-1:0]  wr_addr,
    output logic [DBITS-1:0]  wr_data,
    output logic              wr_en,
    output logic              mx_start,
    input  logic              mx_stop,
    input  logic [BITLEN-1:0] mx_ans,
    output logic              tx_start,
    output logic [BITLEN-1:0] tx_data,
    input  logic              tx_done,
    output logic              rx_enable,
    output logic              busy,
    output logic              err,
    output logic              coll,
    output logic              ovr,
    output logic [2:0]        state
);
    state_t st, nx;
    logic [TMO_BITS-1:0] wd;
    logic wd_exp, drop;
    always_comb begin
        nx = st;
        case (st)
            IDLE:    nx = ld_valid ? START : IDLE;
            START:   nx = RUN;
            RUN:     nx = mx_stop ? SEND : (wd_exp ? ERR : RUN);
            SEND:    nx = WAIT_TX;
            WAIT_TX: nx = tx_done ? IDLE : WAIT_TX;
            ERR:     nx = clr ? IDLE : ERR;
            default: nx = IDLE;
        endcase
    end
    assign wd_exp    = &wd;
    assign mx_start  = st == START;
    assign tx_start  = st == SEND;
    assign rx_enable = st == IDLE;
    assign busy      = st != IDLE;
    assign err       = st == ERR;
    assign state     = st;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            wd      <= '0;
            tx_data <= '0;
            coll    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            st <= nx;
            if (st == START)
                wd <= '0;
            else if (st == RUN && !wd_exp)
                wd <= wd + 1'b1;
            if (st == RUN && mx_stop)
                tx_data <= mx_ans;
            coll <= clr ? 1'b0 : (coll | drop);
            ovr  <= clr ? 1'b0 : (ovr | (ld_valid & (st != IDLE)));
        end
    end
    bram_wr_arb #(.ABITS(ABITS), .DBITS(DBITS)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .own_ld     (st == IDLE),
        .own_mx     (st == START || st == RUN),
        .ld_wr_addr (ld_wr_addr),
        .ld_wr_data (ld_wr_data),
        .ld_wr_en   (ld_wr_en),
        .mx_wr_addr (mx_wr_addr),
        .mx_wr_data (mx_wr_data),
        .mx_wr_en   (mx_wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .drop       (drop)
    );
endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// tb_rsa_seq_ctrl: directed table plus hand sequences for the RSA sequencer (TMO_BITS=4)
module tb_rsa_seq_ctrl;
    logic clk = 0, rst = 1, clr = 0, ld_valid = 0, ld_wr_en = 0, mx_wr_en = 0;
    logic mx_stop = 0, tx_done = 0;
    logic [7:0] ld_wr_addr = 0, mx_wr_addr = 0, wr_addr;
    logic [15:0] ld_wr_data = 0, mx_wr_data = 0, wr_data, mx_ans = 0, tx_data;
    logic wr_en, mx_start, tx_start, rx_enable, busy, err, coll, ovr;
    logic [2:0] state;
    int checks = 0, failures = 0;
    rsa_seq_ctrl #(.BITLEN(16), .ABITS(8), .DBITS(16), .TMO_BITS(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ld_valid(ld_valid),
        .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data), .ld_wr_en(ld_wr_en),
        .mx_wr_addr(mx_wr_addr), .mx_wr_data(mx_wr_data), .mx_wr_en(mx_wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .mx_start(mx_start), .mx_stop(mx_stop), .mx_ans(mx_ans),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .rx_enable(rx_enable), .busy(busy), .err(err), .coll(coll), .ovr(ovr),
        .state(state)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic clr, ldv, mxs, txd, ldwe;
        logic [7:0] la;
        logic [15:0] ld;
        logic mxwe;
        logic [7:0] ma;
        logic [15:0] md, ans;
        logic [2:0] st;
        logic mxst, txst, rx;
        logic [15:0] txdata;
        logic wre;
        logic [7:0] wra;
        logic [15:0] wrd;
        logic coll, ovr;
    } vec_t;
    vec_t tv[10];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_in();
        clr = 0; ld_valid = 0; mx_stop = 0; tx_done = 0; ld_wr_en = 0; mx_wr_en = 0;
    endtask
    initial begin
        int k, runs, mxs_cnt, mxs_at, txs_at, idle_at;
        logic [15:0] txd_at_send;
        //        clr ldv mxs txd ldwe la    ld        mxwe ma    md        ans         st  mxs txs rx txdata     wre wra   wrd       coll ovr
        tv[0] = '{0, 0, 0, 0, 1, 8'h03, 16'hBEEF, 1, 8'h07, 16'h7777, 16'h0000, 3'd0, 0, 0, 1, 16'h0000, 1, 8'h03, 16'hBEEF, 1, 0};
        tv[1] = '{1, 1, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 16'h0000, 0, 8'h03, 16'hBEEF, 0, 0};
        tv[2] = '{0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 3'd2, 0, 0, 0, 16'h0000, 0, 8'h03, 16'hBEEF, 0, 0};
        tv[3] = '{0, 1, 0, 0, 0, 8'h00, 16'h0000, 1, 8'h05, 16'h1111, 16'h0000, 3'd2, 0, 0, 0, 16'h0000, 1, 8'h05, 16'h1111, 0, 1};
        tv[4] = '{0, 0, 0, 0, 1, 8'h09, 16'h9999, 0, 8'h00, 16'h0000, 16'h0000, 3'd2, 0, 0, 0, 16'h0000, 0, 8'h05, 16'h1111, 1, 1};
        tv[5] = '{0, 0, 1, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'hCAFE, 3'd3, 0, 1, 0, 16'hCAFE, 0, 8'h05, 16'h1111, 1, 1};
        tv[6] = '{0, 0, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 3'd4, 0, 0, 0, 16'hCAFE, 0, 8'h05, 16'h1111, 1, 1};
        tv[7] = '{0, 1, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 3'd4, 0, 0, 0, 16'hCAFE, 0, 8'h05, 16'h1111, 1, 1};
        tv[8] = '{0, 0, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 16'hCAFE, 0, 8'h05, 16'h1111, 1, 1};
        tv[9] = '{1, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 16'hCAFE, 0, 8'h05, 16'h1111, 0, 0};
        #12;
        chk("rst_state", state, 0);
        chk("rst_rx", rx_enable, 1);
        chk("rst_txdata", tx_data, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_flags", {busy, err, coll, ovr, mx_start, tx_start}, 0);
        @(negedge clk) rst = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            clr = tv[i].clr; ld_valid = tv[i].ldv; mx_stop = tv[i].mxs; tx_done = tv[i].txd;
            ld_wr_en = tv[i].ldwe; ld_wr_addr = tv[i].la; ld_wr_data = tv[i].ld;
            mx_wr_en = tv[i].mxwe; mx_wr_addr = tv[i].ma; mx_wr_data = tv[i].md; mx_ans = tv[i].ans;
            step();
            chk($sformatf("v%0d_state", i), state, tv[i].st);
            chk($sformatf("v%0d_mx_start", i), mx_start, tv[i].mxst);
            chk($sformatf("v%0d_tx_start", i), tx_start, tv[i].txst);
            chk($sformatf("v%0d_rx", i), rx_enable, tv[i].rx);
            chk($sformatf("v%0d_busy", i), busy, tv[i].st != 0);
            chk($sformatf("v%0d_tx_data", i), tx_data, tv[i].txdata);
            chk($sformatf("v%0d_wr", i), {wr_en, wr_addr, wr_data}, {tv[i].wre, tv[i].wra, tv[i].wrd});
            chk($sformatf("v%0d_flags", i), {coll, ovr}, {tv[i].coll, tv[i].ovr});
        end
        idle_in();
        // nominal timing: ld_valid at 0, mx_stop at 10, tx_done at 30
        mxs_cnt = 0; mxs_at = -1; txs_at = -1; idle_at = -1; txd_at_send = 0;
        for (k = 0; k < 34; k++) begin
            ld_valid = k == 0; mx_stop = k == 10; tx_done = k == 30;
            mx_ans = (k == 10) ? 16'h1234 : 16'hDEAD;
            step();
            if (mx_start) begin mxs_cnt++; mxs_at = k + 1; end
            if (tx_start) begin txs_at = k + 1; txd_at_send = tx_data; end
            if (state == 0 && idle_at < 0) idle_at = k + 1;
        end
        idle_in();
        chk("nom_mx_start_cnt", mxs_cnt, 1);
        chk("nom_mx_start_at", mxs_at, 1);
        chk("nom_tx_start_at", txs_at, 11);
        chk("nom_tx_data", txd_at_send, 16'h1234);
        chk("nom_idle_at", idle_at, 31);
        chk("nom_rx", rx_enable, 1);
        // watchdog: no mx_stop, ERR after 16 RUN cycles
        ld_valid = 1; step(); ld_valid = 0;
        chk("wd_start", state, 1);
        runs = 0;
        for (k = 0; k < 40; k++) begin
            step();
            if (state != 2) break;
            runs++;
        end
        chk("wd_run_cycles", runs, 16);
        chk("wd_state", state, 5);
        chk("wd_err", {err, busy, rx_enable}, 3'b110);
        ld_valid = 1; mx_stop = 1; mx_ans = 16'h5555; step(); idle_in();
        chk("err_hold_state", state, 5);
        chk("err_hold_ovr", ovr, 1);
        chk("err_tx_data", tx_data, 16'h1234);
        clr = 1; step(); clr = 0;
        chk("clr_state", {state, err, ovr}, {3'd0, 2'b00});
        ld_valid = 1; step(); ld_valid = 0; step();
        chk("rerun_run", state, 2);
        mx_stop = 1; mx_ans = 16'h0F0F; step(); mx_stop = 0;
        chk("rerun_send", {state, tx_start}, {3'd3, 1'b1});
        chk("rerun_tx_data", tx_data, 16'h0F0F);
        step(); tx_done = 1; step(); tx_done = 0;
        chk("rerun_idle", {state, rx_enable}, {3'd0, 1'b1});
        // mx_stop coinciding with watchdog expiry
        ld_valid = 1; step(); ld_valid = 0; step();
        runs = 0;
        for (k = 0; k < 15; k++) begin
            step();
            if (state == 2) runs++;
        end
        chk("sim_pre_run", runs, 15);
        mx_stop = 1; mx_ans = 16'hABCD; step(); mx_stop = 0;
        chk("sim_send", state, 3);
        chk("sim_tx_data", tx_data, 16'hABCD);
        step();
        chk("sim_wait", state, 4);
        // async reset while in WAIT_TX
        #2 rst = 1;
        #1;
        chk("ars_state", state, 0);
        chk("ars_tx_data", tx_data, 0);
        chk("ars_rx", rx_enable, 1);
        @(negedge clk) rst = 0;
        step();
        chk("ars_after", {state, busy}, {3'd0, 1'b0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
